// File: rtl/pcie_regfile_target.sv
// PCIe memory-target register bank on the ECP3 16-bit TLP user interface.
// Decodes MRd/MWr bursts into NUM_REGS x 32-bit registers and returns (Cpl/CplD) completions.
module pcie_regfile_target #(
    parameter int          NUM_REGS  = 16,
    parameter logic [6:0]  BAR_MASK  = 7'b0000011,
    parameter int          MAX_RD_DW = 4,
    parameter logic [31:0] RESET_VAL = 32'hFFFFFFFF
) (
    input  logic                     clk_125,
    input  logic                     core_rst_n,
    input  logic [15:0]              rx_data,
    input  logic                     rx_st,
    input  logic                     rx_end,
    input  logic [6:0]               rx_bar_hit,
    input  logic [7:0]               bus_num,
    input  logic [4:0]               dev_num,
    input  logic [2:0]               func_num,
    input  logic                     tx_rdy,
    output logic                     tx_req,
    output logic                     tx_st,
    output logic                     tx_end,
    output logic [15:0]              tx_data,
    output logic                     ph_cr,
    output logic                     pd_cr,
    output logic                     nph_cr,
    output logic                     npd_cr,
    output logic [7:0]               pd_num,
    output logic [NUM_REGS*32-1:0]   regs_out,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int AW    = (IDX_W > 5) ? IDX_W : 5;
    localparam int RB_W  = (MAX_RD_DW > 1) ? $clog2(MAX_RD_DW) : 1;
    localparam int RB_N  = 1 << RB_W;

    typedef enum logic [3:0] {
        RX_HEAD0, RX_HEAD1, RX_REQ2, RX_REQ3, RX_A64_HI0, RX_A64_HI1,
        RX_ADDR0, RX_ADDR1, RX_DATA
    } rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_HDR, TX_DATA} tx_state_t;

    rx_state_t      r_rx_state, w_rx_next;
    tx_state_t      r_tx_state, w_tx_next;
    logic [1:0]     r_fmt;
    logic [4:0]     r_type;
    logic [9:0]     r_length;
    logic [15:0]    r_reqid;
    logic [7:0]     r_tag;
    logic [3:0]     r_firstbe, r_lastbe;
    logic [AW-1:0]  r_addr;
    logic           r_hit;
    logic           r_half;
    logic [9:0]     r_dw_cnt;
    logic [15:0]    r_hi;
    logic [31:0]    r_regs [NUM_REGS];
    logic [31:0]    r_rdbuf [RB_N];
    logic [NUM_REGS-1:0] r_wr_pulse;
    logic           r_rd_pend;
    logic           r_cpl_ur;
    logic [4:0]     r_cpl_len;
    logic [11:0]    r_cpl_bc;
    logic [6:0]     r_cpl_la;
    logic [7:0]     r_cpl_tag;
    logic [15:0]    r_cpl_reqid;
    logic [4:0]     r_tx_cnt, w_tx_cnt_next;
    logic           w_tx_done;

    function automatic logic [2:0] f_tz(input logic [3:0] be);
        if (be[0])      return 3'd0;
        else if (be[1]) return 3'd1;
        else if (be[2]) return 3'd2;
        else if (be[3]) return 3'd3;
        else            return 3'd4;
    endfunction

    function automatic logic [2:0] f_lz(input logic [3:0] be);
        if (be[3])      return 3'd0;
        else if (be[2]) return 3'd1;
        else if (be[1]) return 3'd2;
        else if (be[0]) return 3'd3;
        else            return 3'd4;
    endfunction

    // Address and hit are still on the bus during ADDR1, where an MRd ends.
    logic [AW-1:0]    w_addr;
    logic             w_hit;
    logic [IDX_W-1:0] w_base;
    assign w_addr = (r_rx_state == RX_ADDR1) ? rx_data[AW+1:2] : r_addr;
    assign w_hit  = (r_rx_state == RX_ADDR1) ? |(rx_bar_hit & BAR_MASK) : r_hit;
    assign w_base = w_addr[IDX_W-1:0];

    logic w_is_mrd, w_is_mrdlk, w_is_mwr, w_is_msg, w_is_iocfg, w_rx_done, w_snap;
    assign w_is_mrd   = !r_fmt[1] && (r_type == 5'b00000);
    assign w_is_mrdlk = !r_fmt[1] && (r_type == 5'b00001);
    assign w_is_mwr   =  r_fmt[1] && (r_type == 5'b00000);
    assign w_is_msg   = (r_type[4:3] == 2'b10);
    assign w_is_iocfg = (r_type == 5'b00010) || (r_type[4:1] == 4'b0010);
    assign w_rx_done  = rx_end && (r_rx_state != RX_HEAD0);
    assign w_snap     = w_rx_done && w_is_mrd && w_hit && !r_rd_pend;

    always_ff @(posedge clk_125) begin
        if (!core_rst_n) r_rx_state <= RX_HEAD0;
        else             r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_HEAD0:   if (rx_st) w_rx_next = RX_HEAD1;
            RX_HEAD1:   w_rx_next = RX_REQ2;
            RX_REQ2:    w_rx_next = RX_REQ3;
            RX_REQ3:    w_rx_next = r_fmt[0] ? RX_A64_HI0 : RX_ADDR0;
            RX_A64_HI0: w_rx_next = RX_A64_HI1;
            RX_A64_HI1: w_rx_next = RX_ADDR0;
            RX_ADDR0:   w_rx_next = RX_ADDR1;
            RX_ADDR1:   w_rx_next = RX_DATA;
            default:    w_rx_next = r_rx_state;
        endcase
        if (rx_end) w_rx_next = RX_HEAD0;
    end

    always_ff @(posedge clk_125) begin
        case (r_rx_state)
            RX_HEAD0: if (rx_st) begin
                r_fmt  <= rx_data[14:13];
                r_type <= rx_data[12:8];
            end
            RX_HEAD1: r_length <= rx_data[9:0];
            RX_REQ2:  r_reqid  <= rx_data;
            RX_REQ3: begin
                r_tag     <= rx_data[15:8];
                r_lastbe  <= rx_data[7:4];
                r_firstbe <= rx_data[3:0];
            end
            RX_ADDR1: begin
                r_addr   <= w_addr;
                r_hit    <= w_hit;
                r_half   <= 1'b0;
                r_dw_cnt <= '0;
            end
            RX_DATA: begin
                r_half <= !r_half;
                if (!r_half) r_hi <= rx_data;
                else         r_dw_cnt <= r_dw_cnt + 10'd1;
            end
            default: ;
        endcase
    end

    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic [3:0]       w_wr_be;
    logic [31:0]      w_wr_dw;
    assign w_wr_en  = (r_rx_state == RX_DATA) && r_half && w_is_mwr && r_hit;
    assign w_wr_idx = r_addr[IDX_W-1:0] + r_dw_cnt[IDX_W-1:0];
    assign w_wr_dw  = {r_hi, rx_data};
    assign w_wr_be  = (r_dw_cnt == 10'd0)            ? r_firstbe :
                      (r_dw_cnt == r_length - 10'd1) ? r_lastbe  : 4'hF;

    // BE bit b enables the byte that arrived b-th on the wire (bit0 -> [31:24]).
    always_ff @(posedge clk_125) begin
        if (!core_rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VAL;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (w_wr_be[b]) r_regs[w_wr_idx][31-8*b -: 8] <= w_wr_dw[31-8*b -: 8];
                if (|w_wr_be) r_wr_pulse[w_wr_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_125) begin
        if (!core_rst_n) begin
            for (int k = 0; k < RB_N; k++) r_rdbuf[k] <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            if (w_snap) begin
                for (int k = 0; k < RB_N; k++) r_rdbuf[k] <= r_regs[w_base + IDX_W'(k)];
                r_rd_pend <= 1'b1;
            end else if (w_tx_done) begin
                r_rd_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_125) begin
        if (w_snap) begin
            r_cpl_ur    <= (r_length == 10'd0) || (r_length > 10'(MAX_RD_DW));
            r_cpl_len   <= ((r_length == 10'd0) || (r_length > 10'(MAX_RD_DW))) ? 5'd0 : r_length[4:0];
            r_cpl_tag   <= r_tag;
            r_cpl_reqid <= r_reqid;
            r_cpl_la    <= {w_addr[4:0], (r_firstbe == 4'h0) ? 2'b00 : f_tz(r_firstbe)[1:0]};
            if ((r_length == 10'd0) || (r_length > 10'(MAX_RD_DW)))
                r_cpl_bc <= 12'd4;
            else if (r_length == 10'd1)
                r_cpl_bc <= (r_firstbe == 4'h0) ? 12'd1 :
                            12'd4 - 12'(f_tz(r_firstbe)) - 12'(f_lz(r_firstbe));
            else
                r_cpl_bc <= 12'({r_length, 2'b00}) - 12'(f_tz(r_firstbe)) - 12'(f_lz(r_lastbe));
        end
    end

    always_ff @(posedge clk_125) begin
        if (!core_rst_n) begin
            ph_cr  <= 1'b0;
            pd_cr  <= 1'b0;
            nph_cr <= 1'b0;
            npd_cr <= 1'b0;
            pd_num <= 8'd0;
        end else begin
            ph_cr  <= 1'b0;
            pd_cr  <= 1'b0;
            nph_cr <= 1'b0;
            npd_cr <= 1'b0;
            pd_num <= 8'd0;
            if (w_rx_done) begin
                if (w_is_mwr || (w_is_msg && r_fmt[1])) begin
                    ph_cr  <= 1'b1;
                    pd_cr  <= 1'b1;
                    pd_num <= 8'((11'(r_length) + 11'd3) >> 2);
                end else if (w_is_msg) begin
                    ph_cr <= 1'b1;
                end else if (w_is_iocfg) begin
                    nph_cr <= 1'b1;
                    npd_cr <= r_fmt[1];
                end else if (w_is_mrdlk || (w_is_mrd && !w_snap)) begin
                    nph_cr <= 1'b1;
                end
            end
            // Read credit is withheld until the completion has gone out.
            if (w_tx_done) nph_cr <= 1'b1;
        end
    end

    always_ff @(posedge clk_125) begin
        if (!core_rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_cnt   <= w_tx_cnt_next;
        end
    end

    always_comb begin
        w_tx_next     = r_tx_state;
        w_tx_cnt_next = r_tx_cnt;
        w_tx_done     = 1'b0;
        tx_req        = 1'b0;
        tx_st         = 1'b0;
        tx_end        = 1'b0;
        tx_data       = 16'h0000;
        case (r_tx_state)
            TX_IDLE: if (r_rd_pend) w_tx_next = TX_REQ;
            TX_REQ: begin
                tx_req = 1'b1;
                if (tx_rdy) begin
                    w_tx_next     = TX_HDR;
                    w_tx_cnt_next = '0;
                end
            end
            TX_HDR: begin
                tx_st = (r_tx_cnt == 5'd0);
                case (r_tx_cnt)
                    5'd0:    tx_data = {1'b0, r_cpl_ur ? 2'b00 : 2'b10, 5'b01010, 8'h00};
                    5'd1:    tx_data = {11'd0, r_cpl_len};
                    5'd2:    tx_data = {bus_num, dev_num, func_num};
                    5'd3:    tx_data = {r_cpl_ur ? 3'b001 : 3'b000, 1'b0, r_cpl_bc};
                    5'd4:    tx_data = r_cpl_reqid;
                    default: tx_data = {r_cpl_tag, 1'b0, r_cpl_la};
                endcase
                if (r_tx_cnt == 5'd5) begin
                    w_tx_cnt_next = '0;
                    if (r_cpl_ur) begin
                        tx_end    = 1'b1;
                        w_tx_done = 1'b1;
                        w_tx_next = TX_IDLE;
                    end else begin
                        w_tx_next = TX_DATA;
                    end
                end else begin
                    w_tx_cnt_next = r_tx_cnt + 5'd1;
                end
            end
            default: begin
                tx_data = r_tx_cnt[0] ? r_rdbuf[r_tx_cnt[RB_W:1]][15:0]
                                      : r_rdbuf[r_tx_cnt[RB_W:1]][31:16];
                w_tx_cnt_next = r_tx_cnt + 5'd1;
                if (r_tx_cnt == {4'(r_cpl_len - 5'd1), 1'b1}) begin
                    tx_end    = 1'b1;
                    w_tx_done = 1'b1;
                    w_tx_next = TX_IDLE;
                end
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_out
            assign regs_out[32*gi +: 32] = r_regs[gi];
        end
    endgenerate
    assign reg_wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_pcie_regfile_target.sv
// Directed bench for pcie_regfile_target: reads, bursts, wrap, UR, BAR miss, reset mid-completion.
module tb_pcie_regfile_target;
    logic         clk = 1'b0;
    logic         core_rst_n;
    logic [15:0]  rx_data;
    logic         rx_st, rx_end, tx_rdy;
    logic [6:0]   rx_bar_hit;
    logic [7:0]   bus_num = 8'h01;
    logic [4:0]   dev_num = 5'h02;
    logic [2:0]   func_num = 3'h3;
    logic         tx_req, tx_st, tx_end, ph_cr, pd_cr, nph_cr, npd_cr;
    logic [15:0]  tx_data;
    logic [7:0]   pd_num;
    logic [511:0] regs_out;
    logic [15:0]  reg_wr_pulse;

    pcie_regfile_target dut (
        .clk_125(clk), .core_rst_n(core_rst_n), .rx_data(rx_data), .rx_st(rx_st),
        .rx_end(rx_end), .rx_bar_hit(rx_bar_hit), .bus_num(bus_num), .dev_num(dev_num),
        .func_num(func_num), .tx_rdy(tx_rdy), .tx_req(tx_req), .tx_st(tx_st),
        .tx_end(tx_end), .tx_data(tx_data), .ph_cr(ph_cr), .pd_cr(pd_cr),
        .nph_cr(nph_cr), .npd_cr(npd_cr), .pd_num(pd_num), .regs_out(regs_out),
        .reg_wr_pulse(reg_wr_pulse)
    );

    always #4 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, end_cyc = -1, nph_cyc = -1, n_pkts = 0, n_nph = 0, n_req = 0;
    int wp_cnt [16];
    logic in_pkt = 1'b0;
    logic [15:0] txq[$], expq[$], pkt[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture completions, credits and write strobes mid-cycle.
    always @(negedge clk) begin
        if (tx_st === 1'b1) begin txq.delete(); in_pkt = 1'b1; end
        if (in_pkt) txq.push_back(tx_data);
        if (tx_end === 1'b1) begin in_pkt = 1'b0; end_cyc = cyc; n_pkts++; end
        if (nph_cr === 1'b1) begin n_nph++; nph_cyc = cyc; end
        if (tx_req === 1'b1) n_req++;
        for (int i = 0; i < 16; i++) if (reg_wr_pulse[i] === 1'b1) wp_cnt[i]++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_pkt(input string tag);
        chk({tag, "_nwords"}, 32'(txq.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), (i < txq.size()) ? 32'(txq[i]) : 32'hDEAD_0000, 32'(expq[i]));
        $display("packet %s: %0d half-words checked", tag, expq.size());
    endtask

    task automatic hdr(input logic [15:0] h0, input logic [31:0] addr, input logic [9:0] len,
                       input logic [3:0] fbe, input logic [3:0] lbe, input logic [7:0] tag);
        pkt.delete();
        pkt.push_back(h0);
        pkt.push_back({6'b0, len});
        pkt.push_back(16'hABCD);
        pkt.push_back({tag, lbe, fbe});
        pkt.push_back(addr[31:16]);
        pkt.push_back({addr[15:2], 2'b00});
    endtask

    task automatic send(input logic [6:0] bar);
        for (int i = 0; i < pkt.size(); i++) begin
            rx_data = pkt[i]; rx_st = (i == 0); rx_end = (i == pkt.size() - 1); rx_bar_hit = bar;
            tick();
        end
        rx_data = '0; rx_st = 1'b0; rx_end = 1'b0; rx_bar_hit = '0;
    endtask

    task automatic wait_pkt(input string tag, input int n0);
        for (int i = 0; i < 60 && n_pkts == n0; i++) tick();
        chk({tag, "_done"}, 32'(n_pkts), 32'(n0 + 1));
        tick(); tick();
    endtask

    int nph0, req0, pk0;

    initial begin
        for (int i = 0; i < 16; i++) wp_cnt[i] = 0;
        core_rst_n = 1'b0; rx_data = '0; rx_st = 1'b0; rx_end = 1'b0; rx_bar_hit = '0; tx_rdy = 1'b0;
        repeat (3) tick();
        core_rst_n = 1'b1;
        chk("rst_tx_req", 32'(tx_req), 0);
        chk("rst_tx_st", 32'(tx_st), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_credits", {26'd0, ph_cr, pd_cr, nph_cr, npd_cr, 2'b00}, 0);
        chk("rst_pd_num", 32'(pd_num), 0);
        chk("rst_wr_pulse", 32'(reg_wr_pulse), 0);
        chk("rst_reg0", regs_out[31:0], 32'hFFFFFFFF);
        chk("rst_reg15", regs_out[511:480], 32'hFFFFFFFF);

        // 1: single-DW read, grant delayed to show tx_req holding.
        hdr(16'h0000, 32'h10, 10'd1, 4'hF, 4'h0, 8'h05);
        send(7'b0000001);
        chk("t1_no_early_nph", 32'(nph_cr), 0);
        repeat (3) tick();
        chk("t1_req_held", 32'(tx_req), 1);
        tx_rdy = 1'b1;
        tick();
        chk("t1_req_drop", 32'(tx_req), 0);
        chk("t1_h0_st", 32'(tx_st), 1);
        wait_pkt("t1", 0);
        expq = '{16'h4A00, 16'h0001, 16'h0113, 16'h0004, 16'hABCD, 16'h0510, 16'hFFFF, 16'hFFFF};
        chk_pkt("t1");
        chk("t1_nph_count", 32'(n_nph), 1);
        chk("t1_nph_after_end", 32'(nph_cyc), 32'(end_cyc + 1));

        // 2: three-DW burst with partial first/last byte enables.
        hdr(16'h4000, 32'h04, 10'd3, 4'hC, 4'h3, 8'h00);
        pkt.push_back(16'h1122); pkt.push_back(16'h3344); pkt.push_back(16'h5566);
        pkt.push_back(16'h7788); pkt.push_back(16'h99AA); pkt.push_back(16'hBBCC);
        send(7'b0000010);
        chk("t2_ph_cr", 32'(ph_cr), 1);
        chk("t2_pd_cr", 32'(pd_cr), 1);
        chk("t2_pd_num", 32'(pd_num), 1);
        chk("t2_nph_cr", 32'(nph_cr), 0);
        tick();
        chk("t2_ph_cr_pulse", 32'(ph_cr), 0);
        chk("t2_reg1", regs_out[63:32], 32'hFFFF3344);
        chk("t2_reg2", regs_out[95:64], 32'h55667788);
        chk("t2_reg3", regs_out[127:96], 32'h99AAFFFF);
        chk("t2_wp0", 32'(wp_cnt[0]), 0);
        chk("t2_wp1", 32'(wp_cnt[1]), 1);
        chk("t2_wp2", 32'(wp_cnt[2]), 1);
        chk("t2_wp3", 32'(wp_cnt[3]), 1);

        // 3: burst wrapping from reg15 to reg0.
        hdr(16'h4000, 32'h3C, 10'd2, 4'hF, 4'hF, 8'h00);
        pkt.push_back(16'hDEAD); pkt.push_back(16'hBEEF); pkt.push_back(16'hCAFE); pkt.push_back(16'hF00D);
        send(7'b0000001);
        chk("t3_pd_num", 32'(pd_num), 1);
        tick();
        chk("t3_reg15", regs_out[511:480], 32'hDEADBEEF);
        chk("t3_reg0", regs_out[31:0], 32'hCAFEF00D);
        chk("t3_wp15", 32'(wp_cnt[15]), 1);
        chk("t3_wp0", 32'(wp_cnt[0]), 1);

        // 3b: two-DW wrapped read with partial byte enables.
        pk0 = n_pkts;
        hdr(16'h0000, 32'h3C, 10'd2, 4'hE, 4'h7, 8'h07);
        send(7'b0000001);
        wait_pkt("t3b", pk0);
        expq = '{16'h4A00, 16'h0002, 16'h0113, 16'h0006, 16'hABCD, 16'h073D,
                 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
        chk_pkt("t3b");

        // 4: oversize read gets an Unsupported Request completion.
        pk0 = n_pkts; nph0 = n_nph;
        hdr(16'h0000, 32'h00, 10'd8, 4'hF, 4'hF, 8'h09);
        send(7'b0000001);
        chk("t4_no_early_nph", 32'(nph_cr), 0);
        wait_pkt("t4", pk0);
        expq = '{16'h0A00, 16'h0000, 16'h0113, 16'h2004, 16'hABCD, 16'h0900};
        chk_pkt("t4");
        chk("t4_nph_count", 32'(n_nph), 32'(nph0 + 1));
        chk("t4_nph_after_end", 32'(nph_cyc), 32'(end_cyc + 1));

        // 5: read to a BAR outside the mask.
        req0 = n_req; pk0 = n_pkts;
        hdr(16'h0000, 32'h10, 10'd1, 4'hF, 4'h0, 8'h0A);
        send(7'b0000100);
        chk("t5_nph_now", 32'(nph_cr), 1);
        repeat (10) tick();
        chk("t5_no_req", 32'(n_req), 32'(req0));
        chk("t5_no_pkt", 32'(n_pkts), 32'(pk0));

        // 6: reset pulse during the last data half-word of a completion.
        hdr(16'h0000, 32'h04, 10'd1, 4'hF, 4'h0, 8'h0B);
        send(7'b0000001);
        for (int i = 0; i < 20 && tx_st !== 1'b1; i++) tick();
        chk("t6_found_h0", 32'(tx_st), 1);
        repeat (7) tick();
        chk("t6_d1_tx_end", 32'(tx_end), 1);
        chk("t6_d1_data", 32'(tx_data), 32'h3344);
        nph0 = n_nph;
        core_rst_n = 1'b0;
        tick();
        core_rst_n = 1'b1;
        chk("t6_tx_req", 32'(tx_req), 0);
        chk("t6_tx_st", 32'(tx_st), 0);
        chk("t6_tx_end", 32'(tx_end), 0);
        chk("t6_nph_cr", 32'(nph_cr), 0);
        chk("t6_reg1", regs_out[63:32], 32'hFFFFFFFF);
        chk("t6_reg15", regs_out[511:480], 32'hFFFFFFFF);
        repeat (5) tick();
        chk("t6_no_nph", 32'(n_nph), 32'(nph0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
